flush_redirect_sequencer: RTL
=============================

// Module: flush_redirect_sequencer
// PURPOSE
//  Sequences front-end recovery after a taken branch. Holds the decode flush, drains any in-flight IFU AXI fetch
//  (its returning data is discarded), then issues a single-cycle PC redirect to the IFU.
//  When idle it produces the normal stall controls from IFU-busy and RS-full.
//  Sits between the ALU branch resolution, the IFU, the IF/ID register and issue_logic.
// PARAMETERS
//  XLEN          32  width of branch target / redirect PC
//  FLUSH_CYCLES  1   cycles flush_decode is held after capture (legal range 1..15)
//  CNT_W         32  width of saturating perf counters
// PORTS
//  clk               in   1      clock, rising edge
//  rst               in   1      asynchronous reset, active-high
//  branch_taken      in   1      ALU reports taken/mispredicted branch (1-cycle pulse)
//  branch_target     in   XLEN   redirect PC, valid with branch_taken
//  ifu_busy          in   1      IFU has an outstanding AXI read
//  issue_stall_req   in   1      reservation station full
//  stall_fetch       out  1      hold PC and IF/ID
//  stall_dispatch    out  1      stop issue_logic allocation
//  flush_decode      out  1      convert IF/ID contents to NOP
//  flush_rs          out  1      1-cycle pulse: squash speculative RS entries
//  ifu_discard       out  1      IFU drops the data of the current AXI read
//  pc_redirect_valid out  1      1-cycle pulse: load pc_redirect_addr into PC
//  pc_redirect_addr  out  XLEN   registered target
//  seq_busy          out  1      state != RUN
//  flush_count       out  CNT_W  number of accepted branch_taken events, saturating
//  stall_cycles      out  CNT_W  RUN cycles with stall_fetch=1, saturating
// BEHAVIOUR
//  Reset, asynchronous: state=RUN, target_q=0, flush_cnt=0, both perf counters=0. While rst=1 every output is 0.
//  Reset mid-sequence abandons the pending redirect; no pc_redirect_valid is produced.
//  States:
//   RUN: stall_fetch = ifu_busy|issue_stall_req; stall_dispatch = ifu_busy.
//    On branch_taken: target_q<=branch_target, flush_cnt<=FLUSH_CYCLES-1, next=FLUSH.
//    In that same cycle, combinationally: flush_decode=1, flush_rs=1, stall_fetch=0, stall_dispatch=0.
//    Flush has priority over stall, and this is the zero-latency flush.
//   FLUSH: flush_decode=1, stall_fetch=1, stall_dispatch=1. flush_cnt decrements each cycle.
//    When flush_cnt==0: next=DRAIN if ifu_busy, otherwise REDIRECT.
//   DRAIN: stall_fetch=1, stall_dispatch=1, ifu_discard=1. Wait for ifu_busy==0, then next=REDIRECT.
//    DRAIN has no timeout; the IFU AXI read must terminate.
//   REDIRECT: pc_redirect_valid=1, stall_dispatch=1, stall_fetch=0. Next=RUN.
//  Unlisted outputs in each state are 0. pc_redirect_addr = target_q in every state.
//  Latency: branch_taken at cycle T with ifu_busy=0 -> pc_redirect_valid at T+FLUSH_CYCLES+1.
//   Each DRAIN cycle adds one cycle.
//  branch_taken while in FLUSH or DRAIN: target_q is overwritten (last wins), flush_cnt is reloaded,
//   flush_rs pulses, next=FLUSH.
//  branch_taken while in REDIRECT: pc_redirect_valid is forced to 0 that cycle, target_q is overwritten,
//   flush_rs pulses, next=FLUSH.
//  issue_stall_req is ignored outside RUN, since fetch is already stalled.
//  flush_count increments on every accepted branch_taken. stall_cycles increments in RUN when stall_fetch=1.
//   Both hold at all-ones and do not wrap.
// STRUCTURE
//  Shared header pipeline_ctrl_defs.vh holds state encodings (RUN=2'd0, FLUSH=2'd1, DRAIN=2'd2, REDIRECT=2'd3)
//   and FLUSH_CNT_W=4.
//  Sub-module sat_counter #(CNT_W) with ports clk, rst, inc, count, instantiated twice for the perf counters.
//  Next-state and output logic live in one combinational block; state, target_q and flush_cnt are registered.
// TESTING
//  1 Idle stalls: ifu_busy=1, issue_stall_req=0 -> stall_fetch=1, stall_dispatch=1.
//    issue_stall_req=1 alone -> stall_fetch=1, stall_dispatch=0. stall_cycles increments once per cycle.
//  2 Clean redirect: FLUSH_CYCLES=1, branch_taken @T with target 0x0000_1040, ifu_busy=0
//    -> flush_decode=1 @T and @T+1, flush_rs=1 @T only, pc_redirect_valid=1 with addr 0x1040 @T+2,
//    state back to RUN @T+3, flush_count=1.
//  3 Drain: as test 2 but ifu_busy=1 until T+5 -> ifu_discard=1 @T+2..T+4, pc_redirect_valid @T+5 only.
//  4 Back-to-back: branch_taken @T with target 0x100, then branch_taken @T+1 with target 0x200
//    -> exactly one pc_redirect_valid, addr=0x200, @T+3. flush_count=2.
//  5 Branch in REDIRECT: second branch_taken lands on the REDIRECT cycle
//    -> pc_redirect_valid stays 0 that cycle, then a single redirect to the new target FLUSH_CYCLES+1 cycles later.
//  6 Reset mid-DRAIN: assert rst asynchronously -> all outputs 0 immediately.
//    After release: RUN, counters 0, and no redirect is issued.

Source files
------------

// File: rtl/flush_redirect_sequencer_pkg.sv
// Shared encodings for the front-end flush/redirect sequencer.
// State values match the rest of the pipeline control logic.
package flush_redirect_sequencer_pkg;

    localparam int FLUSH_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_REDIRECT = 2'd3
    } seq_state_e;

endpackage

// File: rtl/flush_redirect_sequencer_sat_counter.sv
// Saturating up-counter used for the sequencer performance counters.
// Holds at all-ones rather than wrapping.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/flush_redirect_sequencer.sv
// Front-end recovery after a taken branch: flush decode, drain the in-flight
// IFU fetch, then pulse a PC redirect. In RUN it produces the normal stalls.
module flush_redirect_sequencer
    import flush_redirect_sequencer_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             branch_taken,
    input  logic [XLEN-1:0]  branch_target,
    input  logic             ifu_busy,
    input  logic             issue_stall_req,
    output logic             stall_fetch,
    output logic             stall_dispatch,
    output logic             flush_decode,
    output logic             flush_rs,
    output logic             ifu_discard,
    output logic             pc_redirect_valid,
    output logic [XLEN-1:0]  pc_redirect_addr,
    output logic             seq_busy,
    output logic [CNT_W-1:0] flush_count,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    seq_state_e             state_q, state_d;
    logic [XLEN-1:0]        target_q, target_d;
    logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic stall_fetch_c, stall_dispatch_c, flush_decode_c, flush_rs_c;
    logic ifu_discard_c, redirect_c, stall_inc;

    always_comb begin
        state_d          = state_q;
        target_d         = target_q;
        flush_cnt_d      = flush_cnt_q;
        stall_fetch_c    = 1'b0;
        stall_dispatch_c = 1'b0;
        flush_decode_c   = 1'b0;
        flush_rs_c       = 1'b0;
        ifu_discard_c    = 1'b0;
        redirect_c       = 1'b0;

        case (state_q)
            ST_RUN: begin
                stall_fetch_c    = ifu_busy | issue_stall_req;
                stall_dispatch_c = ifu_busy;
            end
            ST_FLUSH: begin
                flush_decode_c   = 1'b1;
                stall_fetch_c    = 1'b1;
                stall_dispatch_c = 1'b1;
                if (flush_cnt_q == '0) begin
                    state_d = ifu_busy ? ST_DRAIN : ST_REDIRECT;
                end else begin
                    flush_cnt_d = flush_cnt_q - 1'b1;
                end
            end
            ST_DRAIN: begin
                stall_fetch_c    = 1'b1;
                stall_dispatch_c = 1'b1;
                ifu_discard_c    = 1'b1;
                if (!ifu_busy) begin
                    state_d = ST_REDIRECT;
                end
            end
            ST_REDIRECT: begin
                redirect_c       = 1'b1;
                stall_dispatch_c = 1'b1;
                state_d          = ST_RUN;
            end
        endcase

        // A new branch restarts recovery from any state; last target wins and
        // a redirect to the stale target must not escape in the same cycle.
        if (branch_taken) begin
            target_d       = branch_target;
            flush_cnt_d    = FLUSH_LOAD;
            state_d        = ST_FLUSH;
            flush_decode_c = 1'b1;
            flush_rs_c     = 1'b1;
            redirect_c     = 1'b0;
            if (state_q == ST_RUN) begin
                stall_fetch_c    = 1'b0;
                stall_dispatch_c = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            target_q    <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_inc = (state_q == ST_RUN) && stall_fetch_c;

    // RUN-state outputs follow inputs combinationally, so gate them during reset.
    assign stall_fetch       = stall_fetch_c & ~rst;
    assign stall_dispatch    = stall_dispatch_c & ~rst;
    assign flush_decode      = flush_decode_c & ~rst;
    assign flush_rs          = flush_rs_c & ~rst;
    assign ifu_discard       = ifu_discard_c & ~rst;
    assign pc_redirect_valid = redirect_c & ~rst;
    assign pc_redirect_addr  = target_q;
    assign seq_busy          = (state_q != ST_RUN) & ~rst;

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (branch_taken),
        .count (flush_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (stall_cycles)
    );

endmodule
